// File: rtl/id_hazard_stage.sv
// Decode stage with a local register file, operand forwarding or interlock,
// and branch/jump resolution toward the PC.
module id_hazard_stage #(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IF_to_ID_valid,
  input  logic [63:0]      IF_to_ID_bus,
  output logic             ID_allow_in,
  input  logic             EXE_allow_in,
  output logic             ID_to_EXE_valid,
  output logic [147:0]     ID_to_EXE_bus,
  output logic [32:0]      ID_to_PC_bus,
  input  logic [39:0]      EXE_fwd_bus,
  input  logic [39:0]      MEM_fwd_bus,
  input  logic [37:0]      WB_to_RF_bus,
  output logic [CNT_W-1:0] stall_cnt
);
  // valid/ready: a word moves on a rising edge where the sender's valid and the
  // receiver's allow_in are both high; a valid never depends on allow_in downstream.
  logic        id_valid;
  logic [63:0] id_bus;
  logic        ready_go;

  logic [31:0] rf [32];
  logic [31:0] wb_w_data;
  logic [4:0]  wb_w_addr;
  logic        wb_w_en;

  assign wb_w_data = WB_to_RF_bus[37:6];
  assign wb_w_addr = WB_to_RF_bus[5:1];
  assign wb_w_en   = WB_to_RF_bus[0];

  always_ff @(posedge clk) begin
    if (wb_w_en && wb_w_addr != 5'd0) rf[wb_w_addr] <= wb_w_data;
  end

  logic [31:0] inst, pc4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [31:0] sext_imm;

  assign inst     = id_bus[31:0];
  assign pc4      = id_bus[63:32];
  assign opcode   = inst[31:26];
  assign funct    = inst[5:0];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign sa       = inst[10:6];
  assign sext_imm = {{16{inst[15]}}, inst[15:0]};

  logic [31:0] rs_rf, rt_rf;
  assign rs_rf = (rs == 5'd0) ? 32'd0 : (wb_w_en && wb_w_addr == rs) ? wb_w_data : rf[rs];
  assign rt_rf = (rt == 5'd0) ? 32'd0 : (wb_w_en && wb_w_addr == rt) ? wb_w_data : rf[rt];

  logic [3:0] alu_op;
  logic [1:0] rf_w_data_sel;
  logic       rf_w_en, data_ram_w_en, alu_src1, alu_src2;
  logic       use_rs, use_rt, is_r, is_jr, is_jal, is_beq, is_bne;

  always_comb begin
    alu_op        = 4'hf;
    rf_w_data_sel = 2'b00;
    rf_w_en       = 1'b0;
    data_ram_w_en = 1'b0;
    alu_src1      = 1'b0;
    alu_src2      = 1'b0;
    use_rs        = 1'b1;
    use_rt        = 1'b0;
    is_r          = 1'b0;
    is_jr         = 1'b0;
    is_jal        = 1'b0;
    is_beq        = 1'b0;
    is_bne        = 1'b0;
    case (opcode)
      6'h00: begin
        is_r    = 1'b1;
        use_rt  = 1'b1;
        rf_w_en = 1'b1;
        case (funct)
          6'h21: alu_op = 4'd0;
          6'h23: alu_op = 4'd1;
          6'h2a: alu_op = 4'd2;
          6'h2b: alu_op = 4'd3;
          6'h24: alu_op = 4'd4;
          6'h27: alu_op = 4'd5;
          6'h25: alu_op = 4'd6;
          6'h26: alu_op = 4'd7;
          6'h00: begin alu_op = 4'd8;  alu_src1 = 1'b1; use_rs = 1'b0; end
          6'h02: begin alu_op = 4'd9;  alu_src1 = 1'b1; use_rs = 1'b0; end
          6'h03: begin alu_op = 4'd10; alu_src1 = 1'b1; use_rs = 1'b0; end
          6'h08: begin alu_op = 4'd0;  use_rt = 1'b0; rf_w_en = 1'b0; is_jr = 1'b1; end
          default: begin use_rt = 1'b0; rf_w_en = 1'b0; end
        endcase
      end
      6'h09: begin alu_op = 4'd0; alu_src2 = 1'b1; rf_w_en = 1'b1; end
      6'h23: begin alu_op = 4'd0; alu_src2 = 1'b1; rf_w_en = 1'b1; rf_w_data_sel = 2'b01; end
      6'h2b: begin alu_op = 4'd0; alu_src2 = 1'b1; use_rt = 1'b1; data_ram_w_en = 1'b1; end
      6'h04: begin alu_op = 4'd0; use_rt = 1'b1; is_beq = 1'b1; end
      6'h05: begin alu_op = 4'd0; use_rt = 1'b1; is_bne = 1'b1; end
      6'h03: begin alu_op = 4'd0; use_rs = 1'b0; rf_w_en = 1'b1; rf_w_data_sel = 2'b10; is_jal = 1'b1; end
      6'h0f: begin alu_op = 4'd11; alu_src2 = 1'b1; use_rs = 1'b0; rf_w_en = 1'b1; end
      default: ;
    endcase
  end

  // Returns {stall, value}; without forwarding a pending EXE/MEM write always stalls.
  function automatic logic [32:0] resolve(input logic [4:0] a, input logic used,
                                          input logic [31:0] rf_val,
                                          input logic [39:0] ex, input logic [39:0] mem);
    logic ex_hit, mem_hit;
    ex_hit  = used && a != 5'd0 && ex[39]  && ex[37]  && ex[36:32]  == a;
    mem_hit = used && a != 5'd0 && mem[39] && mem[37] && mem[36:32] == a;
    if (FWD_EN != 0) begin
      if (ex_hit)       resolve = {ex[38], ex[31:0]};
      else if (mem_hit) resolve = {mem[38], mem[31:0]};
      else              resolve = {1'b0, rf_val};
    end else begin
      resolve = {ex_hit | mem_hit, rf_val};
    end
  endfunction

  logic [32:0] rs_res, rt_res;
  logic [31:0] rs_val, rt_val;
  assign rs_res   = resolve(rs, use_rs, rs_rf, EXE_fwd_bus, MEM_fwd_bus);
  assign rt_res   = resolve(rt, use_rt, rt_rf, EXE_fwd_bus, MEM_fwd_bus);
  assign rs_val   = rs_res[31:0];
  assign rt_val   = rt_res[31:0];
  assign ready_go = ~(rs_res[32] | rt_res[32]);

  assign ID_allow_in     = ~id_valid | (ready_go & EXE_allow_in);
  assign ID_to_EXE_valid = id_valid & ready_go;

  logic [4:0] dest;
  assign dest = is_jal ? 5'd31 : is_r ? rd : rt;

  assign ID_to_EXE_bus = {pc4, rs_val, rt_val, sa, sext_imm, dest, alu_src1, alu_src2,
                          alu_op, data_ram_w_en, rf_w_data_sel, rf_w_en};

  // Taken only on the cycle the branch leaves ID, so one pulse per branch.
  logic        br_cond, br_taken;
  logic [31:0] br_target;
  assign br_cond   = is_jr | is_jal | (is_beq & (rs_val == rt_val)) | (is_bne & (rs_val != rt_val));
  assign br_taken  = id_valid & ready_go & EXE_allow_in & br_cond;
  assign br_target = is_jr  ? rs_val :
                     is_jal ? {pc4[31:28], inst[25:0], 2'b00} :
                              pc4 + {sext_imm[29:0], 2'b00};
  assign ID_to_PC_bus = {br_taken, br_target};

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (ID_allow_in) id_valid <= IF_to_ID_valid;
      if (IF_to_ID_valid && ID_allow_in) id_bus <= IF_to_ID_bus;
      if (id_valid && !ready_go) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_id_hazard_stage.sv
// Random and directed stimulus on a forwarding and an interlocked instance,
// checked cycle by cycle against an instruction-level reference model.
module tb_id_hazard_stage;
  typedef enum int {K_ADDU, K_SUBU, K_SLT, K_SLTU, K_AND, K_OR, K_XOR, K_NOR, K_SLL, K_SRL,
                    K_SRA, K_JR, K_ADDIU, K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_LUI, K_UNDEF} kind_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_valid;
  logic [63:0]  if_bus;
  logic         exe_allow;
  logic [39:0]  exe_fwd, mem_fwd;
  logic [37:0]  wb_bus;
  kind_t        cur_kind;
  logic [1:0]   o_allow, o_valid;
  logic [147:0] o_bus [2];
  logic [32:0]  o_pc [2];
  logic [31:0]  o_cnt0;
  logic [3:0]   o_cnt1;

  always #5 clk = ~clk;

  id_hazard_stage #(.FWD_EN(1), .CNT_W(32)) dut_fwd (
    .clk(clk), .reset(reset), .IF_to_ID_valid(if_valid), .IF_to_ID_bus(if_bus),
    .ID_allow_in(o_allow[0]), .EXE_allow_in(exe_allow), .ID_to_EXE_valid(o_valid[0]),
    .ID_to_EXE_bus(o_bus[0]), .ID_to_PC_bus(o_pc[0]), .EXE_fwd_bus(exe_fwd),
    .MEM_fwd_bus(mem_fwd), .WB_to_RF_bus(wb_bus), .stall_cnt(o_cnt0));

  id_hazard_stage #(.FWD_EN(0), .CNT_W(4)) dut_ilk (
    .clk(clk), .reset(reset), .IF_to_ID_valid(if_valid), .IF_to_ID_bus(if_bus),
    .ID_allow_in(o_allow[1]), .EXE_allow_in(exe_allow), .ID_to_EXE_valid(o_valid[1]),
    .ID_to_EXE_bus(o_bus[1]), .ID_to_PC_bus(o_pc[1]), .EXE_fwd_bus(exe_fwd),
    .MEM_fwd_bus(mem_fwd), .WB_to_RF_bus(wb_bus), .stall_cnt(o_cnt1));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference state: index 0 = forwarding instance, 1 = interlocked instance.
  logic        m_valid [2];
  logic [31:0] m_inst [2];
  logic [31:0] m_pc4 [2];
  kind_t       m_kind [2];
  logic [31:0] m_cnt [2];
  logic        e_ready [2];
  logic        e_allow [2];
  logic [31:0] m_rf [32];

  task automatic check(input string tag, input logic [147:0] got, input logic [147:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] encode(kind_t k, logic [4:0] rs, logic [4:0] rt, logic [15:0] lo);
    logic [5:0] fn, op;
    fn = 6'h00;
    op = 6'h3f;
    case (k)
      K_ADDU: fn = 6'h21;  K_SUBU: fn = 6'h23;  K_SLT: fn = 6'h2a;  K_SLTU: fn = 6'h2b;
      K_AND:  fn = 6'h24;  K_OR:   fn = 6'h25;  K_XOR: fn = 6'h26;  K_NOR:  fn = 6'h27;
      K_SLL:  fn = 6'h00;  K_SRL:  fn = 6'h02;  K_SRA: fn = 6'h03;  K_JR:   fn = 6'h08;
      K_ADDIU: op = 6'h09; K_LW: op = 6'h23; K_SW: op = 6'h2b; K_BEQ: op = 6'h04;
      K_BNE:   op = 6'h05; K_JAL: op = 6'h03; K_LUI: op = 6'h0f;
      default: ;
    endcase
    if (k <= K_JR) return {6'h00, rs, rt, lo[15:6], fn};
    return {op, rs, rt, lo};
  endfunction

  function automatic bit uses_rs(kind_t k);
    return !(k inside {K_JAL, K_LUI, K_SLL, K_SRL, K_SRA});
  endfunction

  function automatic bit uses_rt(kind_t k);
    return (k < K_JR) || (k inside {K_SW, K_BEQ, K_BNE});
  endfunction

  // {stall, operand} for one source of the held instruction.
  function automatic logic [32:0] src_value(bit fwd, logic [4:0] a, bit used);
    bit e_hit, m_hit;
    logic [31:0] rf;
    rf = (a == 5'd0) ? 32'd0 : (wb_bus[0] && wb_bus[5:1] == a) ? wb_bus[37:6] : m_rf[a];
    e_hit = used && a != 0 && exe_fwd[39] && exe_fwd[37] && exe_fwd[36:32] == a;
    m_hit = used && a != 0 && mem_fwd[39] && mem_fwd[37] && mem_fwd[36:32] == a;
    if (!fwd) return {e_hit || m_hit, rf};
    if (e_hit) return {exe_fwd[38], exe_fwd[31:0]};
    if (m_hit) return {mem_fwd[38], mem_fwd[31:0]};
    return {1'b0, rf};
  endfunction

  function automatic logic [147:0] exp_bus(kind_t k, logic [31:0] in, logic [31:0] pc4,
                                           logic [31:0] rv, logic [31:0] tv);
    logic [3:0] op;
    logic [4:0] dest;
    logic [1:0] sel;
    case (k)
      K_SUBU: op = 4'd1;  K_SLT: op = 4'd2;  K_SLTU: op = 4'd3;  K_AND: op = 4'd4;
      K_NOR:  op = 4'd5;  K_OR:  op = 4'd6;  K_XOR:  op = 4'd7;  K_SLL: op = 4'd8;
      K_SRL:  op = 4'd9;  K_SRA: op = 4'd10; K_LUI:  op = 4'd11; K_UNDEF: op = 4'd15;
      default: op = 4'd0;
    endcase
    dest = (k == K_JAL) ? 5'd31 : (k <= K_JR) ? in[15:11] : in[20:16];
    sel  = (k == K_LW) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
    return {pc4, rv, tv, in[10:6], {{16{in[15]}}, in[15:0]}, dest,
            k inside {K_SLL, K_SRL, K_SRA}, k inside {K_ADDIU, K_LW, K_SW, K_LUI}, op,
            k == K_SW, sel, !(k inside {K_SW, K_BEQ, K_BNE, K_JR, K_UNDEF})};
  endfunction

  task automatic model_check();
    for (int u = 0; u < 2; u++) begin
      kind_t k;
      logic [31:0] in, rv, tv, tgt, cnt_got;
      logic [32:0] ra, rb;
      logic rdy, cond, take;
      string p;
      p  = (u == 0) ? "fwd" : "ilk";
      k  = m_kind[u];
      in = m_inst[u];
      ra = src_value(u == 0, in[25:21], uses_rs(k));
      rb = src_value(u == 0, in[20:16], uses_rt(k));
      rv = ra[31:0];
      tv = rb[31:0];
      rdy = !(ra[32] || rb[32]);
      e_ready[u] = rdy;
      e_allow[u] = !m_valid[u] || (rdy && exe_allow);
      check({p, ".allow"}, o_allow[u], e_allow[u]);
      check({p, ".valid"}, o_valid[u], m_valid[u] && rdy);
      cnt_got = (u == 0) ? o_cnt0 : {28'd0, o_cnt1};
      check({p, ".stall_cnt"}, cnt_got, m_cnt[u]);
      if (m_valid[u] && rdy) check({p, ".bus"}, o_bus[u], exp_bus(k, in, m_pc4[u], rv, tv));
      cond = (k == K_JR) || (k == K_JAL) || (k == K_BEQ && rv == tv) || (k == K_BNE && rv != tv);
      take = m_valid[u] && rdy && exe_allow && cond;
      tgt  = (k == K_JR) ? rv : (k == K_JAL) ? {m_pc4[u][31:28], in[25:0], 2'b00}
                                             : m_pc4[u] + {{14{in[15]}}, in[15:0], 2'b00};
      check({p, ".br_taken"}, o_pc[u][32], take);
      if (take) exp_q.push_back(tgt);
      if (o_pc[u][32]) begin
        if (exp_q.size() > 0) check({p, ".br_target"}, o_pc[u][31:0], exp_q.pop_front());
        else check({p, ".br_extra"}, o_pc[u][32], 1'b0);
      end else if (take) begin
        void'(exp_q.pop_back());
      end
    end
  endtask

  task automatic probe();
    #1;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        m_valid[u] = 1'b0;
        m_cnt[u]   = 32'd0;
      end else begin
        if (m_valid[u] && !e_ready[u]) m_cnt[u] = (u == 0) ? m_cnt[u] + 1 : (m_cnt[u] + 1) % 16;
        if (e_allow[u]) begin
          m_valid[u] = if_valid;
          if (if_valid) begin
            m_inst[u] = if_bus[31:0];
            m_pc4[u]  = if_bus[63:32];
            m_kind[u] = cur_kind;
          end
        end
      end
    end
    if (wb_bus[0] && wb_bus[5:1] != 0) m_rf[wb_bus[5:1]] = wb_bus[37:6];
    @(negedge clk);
  endtask

  task automatic idle();
    if_valid  = 1'b0;
    if_bus    = 64'd0;
    cur_kind  = K_UNDEF;
    exe_allow = 1'b1;
    exe_fwd   = 40'd0;
    mem_fwd   = 40'd0;
    wb_bus    = 38'd0;
  endtask

  task automatic put(input kind_t k, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [15:0] lo, input logic [31:0] pc4);
    if_valid = 1'b1;
    cur_kind = k;
    if_bus   = {pc4, encode(k, rs, rt, lo)};
  endtask

  function automatic logic [39:0] fwd(logic [4:0] a, logic [31:0] d, logic nr);
    return {1'b1, nr, 1'b1, a, d};
  endfunction

  task automatic do_reset();
    idle();
    reset = 1'b1;
    probe();
    advance();
    reset = 1'b0;
  endtask

  task automatic drive_random();
    cur_kind  = kind_t'($urandom_range(0, 19));
    if_valid  = ($urandom_range(0, 3) != 0);
    if_bus    = {$urandom() & 32'hffff_fffc,
                 encode(cur_kind, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        {3'd0, 2'($urandom_range(0, 3)), 11'($urandom())})};
    exe_allow = ($urandom_range(0, 3) != 0);
    exe_fwd   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 1'($urandom()),
                 5'($urandom_range(0, 7)), $urandom()};
    mem_fwd   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 1'($urandom()),
                 5'($urandom_range(0, 7)), $urandom()};
    wb_bus    = {$urandom(), 5'($urandom_range(0, 7)), 1'($urandom())};
    reset     = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    int pulses;
    m_rf[0] = 32'd0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    advance();
    advance();
    reset = 1'b0;
    probe();
    check("rst.allow", o_allow, 2'b11);
    check("rst.valid", o_valid, 2'b00);
    check("rst.cnt", o_cnt0, 32'd0);
    advance();
    for (int r = 1; r < 32; r++) begin
      idle();
      wb_bus = {$urandom(), 5'(r), 1'b1};
      probe();
      advance();
    end

    // addiu $1,$0,5 ; addu $2,$1,$1 back to back
    do_reset();
    idle(); put(K_ADDIU, 5'd0, 5'd1, 16'd5, 32'h104); probe(); advance();
    idle(); put(K_ADDU, 5'd1, 5'd1, 16'h1000, 32'h108); probe(); advance();
    idle(); exe_fwd = fwd(5'd1, 32'd5, 1'b0); probe();
    check("d1.fwd_valid", o_valid[0], 1'b1);
    check("d1.fwd_rs", o_bus[0][115:84], 32'd5);
    check("d1.fwd_rt", o_bus[0][83:52], 32'd5);
    check("d1.ilk_valid", o_valid[1], 1'b0);
    advance();
    idle(); mem_fwd = fwd(5'd1, 32'd5, 1'b0); probe();
    check("d2.ilk_valid", o_valid[1], 1'b0);
    advance();
    idle(); wb_bus = {32'd5, 5'd1, 1'b1}; probe();
    check("d3.ilk_valid", o_valid[1], 1'b1);
    check("d3.ilk_rs", o_bus[1][115:84], 32'd5);
    check("d3.ilk_rt", o_bus[1][83:52], 32'd5);
    check("d3.ilk_cnt", o_cnt1, 4'd2);
    check("d3.fwd_cnt", o_cnt0, 32'd0);
    advance();

    // lw $3 not ready in EXE, dependent addu
    do_reset();
    idle(); put(K_LW, 5'd0, 5'd3, 16'h0010, 32'h200); probe(); advance();
    idle(); put(K_ADDU, 5'd3, 5'd3, 16'h2000, 32'h204); probe(); advance();
    idle(); exe_fwd = fwd(5'd3, 32'd0, 1'b1); probe();
    check("d4.stall_valid", o_valid[0], 1'b0);
    advance();
    idle(); mem_fwd = fwd(5'd3, 32'hdeadbeef, 1'b0); probe();
    check("d4.valid", o_valid[0], 1'b1);
    check("d4.rs", o_bus[0][115:84], 32'hdeadbeef);
    check("d4.cnt", o_cnt0, 32'd1);
    advance();

    // beq $5,$5,+3 at 0x100 held by back-pressure
    do_reset();
    pulses = 0;
    idle(); put(K_BEQ, 5'd5, 5'd5, 16'd3, 32'h104); probe(); advance();
    for (int i = 0; i < 2; i++) begin
      idle(); exe_allow = 1'b0; probe();
      pulses += int'(o_pc[0][32]);
      advance();
    end
    idle(); probe();
    pulses += int'(o_pc[0][32]);
    check("d5.target", o_pc[0][31:0], 32'h110);
    check("d5.cnt", o_cnt0, 32'd0);
    advance();
    idle(); probe();
    pulses += int'(o_pc[0][32]);
    advance();
    check("d5.pulses", pulses, 1);

    // jr $31 from MEM, plus $0 writes never forwarded
    do_reset();
    idle(); put(K_JR, 5'd31, 5'd0, 16'd0, 32'h300); probe(); advance();
    idle(); mem_fwd = fwd(5'd31, 32'h0bfc0040, 1'b0); exe_fwd = fwd(5'd0, 32'h1234, 1'b0); probe();
    check("d6.taken", o_pc[0][32], 1'b1);
    check("d6.target", o_pc[0][31:0], 32'h0bfc0040);
    advance();
    idle(); put(K_ADDU, 5'd0, 5'd0, 16'h3000, 32'h304); probe(); advance();
    idle(); exe_fwd = fwd(5'd0, 32'hffffffff, 1'b0); mem_fwd = fwd(5'd0, 32'h77, 1'b1); probe();
    check("d7.fwd_valid", o_valid[0], 1'b1);
    check("d7.rs0", o_bus[0][115:84], 32'd0);
    check("d7.rt0", o_bus[0][83:52], 32'd0);
    check("d7.ilk_valid", o_valid[1], 1'b1);
    advance();

    // reset while a jr is stalled
    do_reset();
    idle(); put(K_JR, 5'd3, 5'd0, 16'd0, 32'h400); probe(); advance();
    idle(); exe_fwd = fwd(5'd3, 32'h44, 1'b1); probe();
    check("d8.stalled", o_valid[0], 1'b0);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle(); probe();
      check("d8.no_branch", o_pc[0][32], 1'b0);
      check("d8.allow", o_allow[0], 1'b1);
      check("d8.cnt", o_cnt0, 32'd0);
      advance();
    end

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      probe();
      advance();
    end
    reset = 1'b0;
    check("q.empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
